// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file write side.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned XZR_IDX  = 31;
  localparam int unsigned CNT_W    = 16;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [0:NUM_REGS-1] slice_t;
  typedef logic [CNT_W-1:0]    wr_count_t;

  localparam wr_count_t CNT_MAX = '1;

endpackage

// File: rtl/regfile_write_array_if.sv
// Write port and bit-sliced register view of the integer register file.
interface regfile_write_array_if #(
  parameter int unsigned WIDTH = 64
) ();
  import regfile_pkg::*;

  logic                 wr_en;
  reg_addr_t            wr_addr;
  logic [WIDTH-1:0]     wr_data;
  slice_t [WIDTH-1:0]   regs_out;
  logic                 wr_ack;
  wr_count_t            wr_count;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  regs_out, wr_ack, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output regs_out, wr_ack, wr_count
  );

endinterface

// File: rtl/regfile_write_array_decoder5_32.sv
// One-hot decode of the register write address into per-register load enables.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_array.sv
// X0..X30 storage with hardwired XZR, optional write-through, and a
// bit-sliced view that feeds the per-bit 32:1 read muxes directly.
module regfile_write_array
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_write_array_if.slave bus
);

  logic [NUM_REGS-1:0] load;
  logic                wr_acc;
  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    view   [NUM_REGS];
  slice_t [WIDTH-1:0]  regs_slices;
  logic                ack_q;
  wr_count_t           count_q;

  decoder5_32 u_dec (
    .en     (bus.wr_en),
    .addr   (bus.wr_addr),
    .onehot (load)
  );

  // A write to XZR decodes but is never accepted.
  assign wr_acc = bus.wr_en && !load[XZR_IDX];

  for (genvar r = 0; r < XZR_IDX; r++) begin : g_reg
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        q <= '0;
      end else if (load[r]) begin
        q <= bus.wr_data;
      end
    end

    assign regs_q[r] = q;
  end

  assign regs_q[XZR_IDX] = '0;

  // Same-cycle forwarding of the pending write; XZR is excluded.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      view[r] = regs_q[r];
      if (BYPASS && load[r] && (r != XZR_IDX)) view[r] = bus.wr_data;
    end
  end

  always_comb begin
    regs_slices = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_slices[b][r] = view[r][b];
      end
    end
  end

  assign bus.regs_out = regs_slices;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ack_q <= wr_acc;
      if (wr_acc && (count_q != CNT_MAX)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.wr_ack   = ack_q;
  assign bus.wr_count = count_q;

endmodule

// File: tb/tb_regfile_write_array.sv
// Directed checks of the register file write side with write-through enabled.
module tb_regfile_write_array;
  import regfile_pkg::*;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  regfile_write_array_if #(.WIDTH(W)) bus ();

  regfile_write_array #(.WIDTH(W), .BYPASS(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [4:0]   addr;
    logic [W-1:0] data;
    int           chk;
    logic [W-1:0] exp_during;
    logic [W-1:0] exp_after;
    logic         exp_ack;
    logic [15:0]  exp_count;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [W-1:0] col(input int r);
    logic [W-1:0] v;
    for (int b = 0; b < W; b++) v[b] = bus.regs_out[b][r];
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic [4:0] addr, input logic [W-1:0] data);
    bus.wr_en   = en;
    bus.wr_addr = addr;
    bus.wr_data = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 16'd1};
    vecs[1] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 64'h0,                   64'h0,                   1'b0, 16'd1};
    vecs[2] = '{1'b1, 5'd0,  64'h1,                   0,  64'h1,                   64'h1,                   1'b1, 16'd2};
    vecs[3] = '{1'b1, 5'd30, 64'h8000_0000_0000_0001, 30, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 16'd3};
    vecs[4] = '{1'b0, 5'd5,  64'h0,                   5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 16'd3};
    vecs[5] = '{1'b1, 5'd4,  64'h0F0F,                5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 16'd4};

    reset_n = 1'b0;
    drive(1'b0, 5'd0, '0);
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_popcount", W'($countones(bus.regs_out)), '0);
    check("reset_ack", W'(bus.wr_ack), '0);
    check("reset_count", W'(bus.wr_count), '0);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].en, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check($sformatf("v%0d_during_r%0d", i, vecs[i].chk), col(vecs[i].chk), vecs[i].exp_during);
      check($sformatf("v%0d_during_x31", i), col(31), '0);
      step();
      drive(1'b0, 5'd0, '0);
      @(negedge clk);
      check($sformatf("v%0d_after_r%0d", i, vecs[i].chk), col(vecs[i].chk), vecs[i].exp_after);
      check($sformatf("v%0d_ack", i), W'(bus.wr_ack), W'(vecs[i].exp_ack));
      check($sformatf("v%0d_count", i), W'(bus.wr_count), W'(vecs[i].exp_count));
      check($sformatf("v%0d_after_x31", i), col(31), '0);
    end

    // Back-to-back writes to one register: last wins, ack stays high.
    step();
    drive(1'b1, 5'd7, 64'hA);
    step();
    drive(1'b1, 5'd7, 64'hB);
    @(negedge clk);
    check("b2b_ack_mid", W'(bus.wr_ack), W'(1'b1));
    step();
    drive(1'b0, 5'd0, '0);
    @(negedge clk);
    check("b2b_reg7", col(7), 64'hB);
    check("b2b_ack", W'(bus.wr_ack), W'(1'b1));
    check("b2b_count", W'(bus.wr_count), W'(16'd6));

    // Sweep every writable register on consecutive cycles.
    for (int r = 0; r < 31; r++) begin
      step();
      drive(1'b1, 5'(r), W'(r + 1));
      if (r > 0) begin
        @(negedge clk);
        check($sformatf("sweep_ack_%0d", r), W'(bus.wr_ack), W'(1'b1));
      end
    end
    step();
    drive(1'b0, 5'd0, '0);
    @(negedge clk);
    check("sweep_ack_last", W'(bus.wr_ack), W'(1'b1));
    check("sweep_count", W'(bus.wr_count), W'(16'd37));
    for (int r = 0; r < 31; r++) check($sformatf("sweep_reg%0d", r), col(r), W'(r + 1));
    check("sweep_x31", col(31), '0);

    // Reset wins over a simultaneous write.
    step();
    reset_n = 1'b0;
    drive(1'b1, 5'd3, 64'h1);
    @(negedge clk);
    check("rst_x31", col(31), '0);
    step();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, '0);
    @(negedge clk);
    check("rst_reg3", col(3), '0);
    check("rst_ack", W'(bus.wr_ack), '0);
    check("rst_count", W'(bus.wr_count), '0);
    check("rst_popcount", W'($countones(bus.regs_out)), '0);

    step();
    drive(1'b1, 5'd3, 64'h55);
    step();
    drive(1'b0, 5'd0, '0);
    @(negedge clk);
    check("post_rst_reg3", col(3), 64'h55);
    check("post_rst_ack", W'(bus.wr_ack), W'(1'b1));
    check("post_rst_count", W'(bus.wr_count), W'(16'd1));

    // Counter saturation after 65540 accepted writes since reset.
    step();
    drive(1'b1, 5'd9, 64'h1234);
    repeat (65533) @(posedge clk);
    @(negedge clk);
    check("sat_pre_count", W'(bus.wr_count), W'(16'hFFFE));
    repeat (6) @(posedge clk);
    #1;
    drive(1'b0, 5'd0, '0);
    @(negedge clk);
    check("sat_count", W'(bus.wr_count), W'(16'hFFFF));
    check("sat_ack", W'(bus.wr_ack), W'(1'b1));
    check("sat_reg9", col(9), 64'h1234);
    check("sat_reg3_hold", col(3), 64'h55);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_array.md
Name: regfile_write_array

Overview:
- Write side of the 32-entry, 64-bit integer register file.
- Holds X0..X30 in flops and hardwires X31 (XZR) to zero.
- Decodes a single 5-bit write address.
- Presents all register contents in bit-sliced form: one 32-bit slice per data bit, indexed [0:31] by register number. This form feeds the per-bit 32:1 read multiplexers directly, with no re-wiring.
- Optional write-through bypass, so a register written this cycle is visible to same-cycle reads.

Parameters:
- WIDTH, 64, data bits per register; also the number of bit slices on regs_out.
- BYPASS, 1, 1 = regs_out reflects a pending write combinationally; 0 = regs_out shows flop contents only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  input  1  write strobe for the current cycle.
- wr_addr  input  5  destination register number (0..31).
- wr_data  input  WIDTH  value to write.
- regs_out  output  [WIDTH-1:0] x [0:31]  bit-sliced contents; regs_out[b][r] = bit b of register r.
- wr_ack  output  1  registered; high for one cycle after an accepted write to X0..X30.
- wr_count  output  16  registered count of accepted writes; saturates at 16'hFFFF.

Behaviour:
- Reset (reset_n low at a rising edge):
  - all 31 storage registers become 0; wr_ack=0; wr_count=0.
  - reset has priority over a simultaneous write; that write is dropped and not counted.
- Write acceptance, on a rising edge with reset_n=1:
  - wr_en=1 and wr_addr<31: reg[wr_addr] <= wr_data; wr_ack <= 1; wr_count increments unless already saturated.
  - wr_en=1 and wr_addr=31: discarded; storage unchanged; wr_ack <= 0; wr_count unchanged.
  - wr_en=0: no state change except wr_ack <= 0.
- Write latency: new data is visible on regs_out on the cycle after the edge, regardless of BYPASS.
- BYPASS=1 forwarding:
  - while wr_en=1 and wr_addr<31, slice r=wr_addr of regs_out shows wr_data combinationally in the same cycle.
  - other registers show their flop values.
  - wr_en=1 to X31 is never forwarded.
- X31 column: regs_out[b][31] = 0 for all b, at all times, including during reset and under bypass.
- Registers not addressed hold their value; at most one register changes per cycle.
- Back-to-back writes to the same register on consecutive cycles: the last one wins.
- wr_ack behaviour:
  - pulses once per accepted write.
  - stays high across consecutive accepted writes.
  - is 0 in the cycle after a reset.
- wr_count saturation: 16'hFFFF + accepted write stays 16'hFFFF.
- Reset mid-operation: any write in flight on a reset edge is lost; the next edge with reset_n=1 accepts writes normally.
- No X propagation: storage is only ever loaded from reset or from wr_data.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS=32, ADDR_W=5, XZR_IDX=31
  - typedef reg_addr_t (logic [4:0])
  - typedef slice_t (logic [0:31])
- Sub-module decoder5_32:
  - inputs en and addr[4:0]; output one-hot logic [31:0].
  - all-zero output when en=0.
  - the output drives per-register load enables.
- Storage is instantiated per register with a generate loop.
- The bit-slice transpose to regs_out is done in the top module.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then release → every regs_out[b][r]=0, wr_ack=0, wr_count=0.
- Single write: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF_0123_4567 for one cycle → next cycle regs_out[b][5] matches each data bit; wr_ack=1 for one cycle; wr_count=1. With BYPASS=1, slice 5 already matches during the write cycle.
- XZR discard: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31 → regs_out[*][31]=0 in both the write cycle and the next; wr_ack=0; wr_count unchanged.
- Sweep: write value r+1 to each addr 0..30 on consecutive cycles → each register r holds r+1; wr_ack high continuously; wr_count=31; X31 still 0.
- Reset priority: reset_n=0 together with wr_en=1, addr=3, data=64'h1 → reg3=0, wr_count=0, wr_ack=0.
- Overwrite and saturation:
  - write addr 7 = 64'hA, then addr 7 = 64'hB on the next cycle → reg7=64'hB.
  - after 65 540 accepted writes, wr_count=16'hFFFF.
